// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI/UART receiver: synchroniser, mid-bit sampling FSM, FWFT receive FIFO
// Define MIDI_UART_RX_ERRCNT_EN to build the saturating framing-error counter.
module midi_uart_rx #(
  parameter int CLK_HZ      = 25000000,
  parameter int BAUD        = 31250,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_25,
  input  logic                          rst,
  input  logic                          midi_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [7:0]                    err_count
);

  localparam int TICKS = CLK_HZ / BAUD;
  localparam int HALF  = TICKS / 2;
  localparam int TW    = $clog2(TICKS);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
  localparam logic [TW-1:0] TICKS_M1 = TW'(TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic                   w_rxs;
  logic [TW-1:0]          r_tick;
  logic [TW-1:0]          w_tick_nx;
  logic [BW-1:0]          r_bit;
  logic [BW-1:0]          w_bit_nx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nx;
  logic                   w_push;
  logic                   w_ferr;

  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_wr;
  logic                   w_ovr;
  logic                   r_frame_err;
  logic                   r_overrun;

  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], midi_rx};
      r_rxs_prev <= w_rxs;
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tick  <= w_tick_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = r_tick;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs && r_rxs_prev) begin
          w_state_nx = S_START;
          w_tick_nx  = '0;
        end
      end
      S_START: begin
        // A start bit that is no longer low at mid-bit is treated as line noise.
        if (r_tick == HALF_M1) begin
          w_tick_nx = '0;
          w_bit_nx  = '0;
          w_state_nx = w_rxs ? S_IDLE : S_DATA;
        end else begin
          w_tick_nx = r_tick + TW'(1);
        end
      end
      S_DATA: begin
        if (r_tick == TICKS_M1) begin
          w_tick_nx  = '0;
          w_shift_nx = {w_rxs, r_shift[DATA_BITS-1:1]};
          if (r_bit == BIT_LAST) begin
            w_bit_nx   = '0;
            w_state_nx = S_STOP;
          end else begin
            w_bit_nx = r_bit + BW'(1);
          end
        end else begin
          w_tick_nx = r_tick + TW'(1);
        end
      end
      S_STOP: begin
        if (r_tick == TICKS_M1) begin
          w_tick_nx = '0;
          if (w_rxs) begin
            w_push     = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_ferr     = 1'b1;
            w_state_nx = S_BREAK;
          end
        end else begin
          w_tick_nx = r_tick + TW'(1);
        end
      end
      S_BREAK: begin
        if (w_rxs) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A pop frees the slot in the same cycle, so a full FIFO can still accept a byte.
  assign w_pop  = (r_count != '0) && rx_ready;
  assign w_full = (r_count == DEPTH_C);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovr  = w_push && w_full && !w_pop;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
    end
  end

`ifdef MIDI_UART_RX_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_ferr && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign rx_data    = r_mem[r_rptr];
  assign rx_valid   = (r_count != '0);
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - scoreboard bench for midi_uart_rx at 32 clocks per bit
module tb_midi_uart_rx;
  localparam int CLK_HZ = 25000000;
  localparam int BAUD   = 781250;
  localparam int T      = CLK_HZ / BAUD;
  localparam int H      = T / 2;
  localparam int DB     = 8;
  localparam int FD     = 4;
  localparam int LAT    = 3 + H + (DB + 1) * T;
`ifdef MIDI_UART_RX_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic       clk_25 = 1'b0;
  logic       rst = 1'b1;
  logic       midi_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .FIFO_DEPTH(FD), .SYNC_STAGES(2)
  ) dut (
    .clk_25(clk_25), .rst(rst), .midi_rx(midi_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .err_count(err_count)
  );

  always #5 clk_25 = ~clk_25;

  int total = 0;
  int bad = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_pop = 0;
  int ready_mode = 0;
  logic [7:0] exp_q [$];
  int n, c, f0, o0, p0, nerr_exp;
  bit seen_busy;
  logic [7:0] b;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Consumer: rx_ready changes just after the rising edge, held for the next edge.
  initial forever begin
    @(posedge clk_25);
    #1;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every accepted head byte is compared with the scoreboard.
  initial forever begin
    logic [7:0] e;
    @(negedge clk_25);
    #1;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (rx_valid && rx_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        check("pop_unexpected", int'(rx_data), -1);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", int'(rx_data), int'(e));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int cycles);
    midi_rx = 1'b1;
    repeat (cycles) @(negedge clk_25);
  endtask

  // Leaves the line at the stop level; captures fifo_count just after the stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                            input bit pop_at_stop, output int cnt_at_stop);
    cnt_at_stop = -1;
    midi_rx = 1'b0;
    repeat (T) @(negedge clk_25);
    for (int i = 0; i < DB; i++) begin
      midi_rx = d[i];
      repeat (T) @(negedge clk_25);
    end
    midi_rx = stop_lvl;
    for (int k = 0; k < T; k++) begin
      if (pop_at_stop && k == H + 1) ready_mode = 1;
      if (k == H + 3) begin
        #2;
        cnt_at_stop = int'(fifo_count);
      end
      @(negedge clk_25);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_25);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    idle(5);

    // single byte, latency from the falling edge
    fork
      send_frame(8'h90, 1'b1, 1'b0, c);
      begin
        n = 0;
        while (!rx_valid && n < LAT + 50) begin
          @(negedge clk_25);
          #1;
          n++;
        end
      end
    join
    check("latency_0x90", n, LAT);
    check("data_0x90", rx_data, 8'h90);
    check("count_0x90", fifo_count, 1);
    exp_q.push_back(8'h90);
    ready_mode = 1;
    idle(4);
    ready_mode = 0;
    check("count_after_pop", fifo_count, 0);

    // short low pulse rejected at mid start bit
    f0 = n_ferr;
    seen_busy = 1'b0;
    midi_rx = 1'b0;
    repeat (H / 2) @(negedge clk_25);
    midi_rx = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      @(negedge clk_25);
      if (busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", seen_busy, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // stop bit low, line held low in break
    f0 = n_ferr;
    send_frame(8'h45, 1'b0, 1'b0, c);
    repeat (3 * T) @(negedge clk_25);
    check("break_busy", busy, 1);
    check("break_ferr", n_ferr - f0, 1);
    check("break_rx_valid", rx_valid, 0);
    midi_rx = 1'b1;
    repeat (6) @(negedge clk_25);
    check("break_exit", busy, 0);
    check("err_count_one", err_count, ERRCNT_ON ? 1 : 0);

    // overrun on the fifth byte
    o0 = n_ovr;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, c);
    idle(4);
    check("ovr_count", fifo_count, FD);
    check("ovr_pulses", n_ovr - o0, 1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    p0 = n_pop;
    ready_mode = 1;
    idle(8);
    ready_mode = 0;
    check("ovr_pops", n_pop - p0, 4);
    check("ovr_drained_valid", rx_valid, 0);

    // full FIFO, pop and push on the same edge
    for (int i = 1; i <= 4; i++) send_frame(8'(i * 8'h11), 1'b1, 1'b0, c);
    idle(2);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i * 8'h11));
    exp_q.push_back(8'hF8);
    o0 = n_ovr;
    send_frame(8'hF8, 1'b1, 1'b1, c);
    check("same_cycle_count", c, FD);
    idle(8);
    ready_mode = 0;
    check("same_cycle_ovr", n_ovr - o0, 0);
    check("same_cycle_drained", exp_q.size(), 0);
    check("same_cycle_count_end", fifo_count, 0);

    // reset in the middle of a frame clears FIFO and partial byte
    send_frame(8'hA5, 1'b1, 1'b0, c);
    idle(4);
    b = 8'hA5;
    midi_rx = 1'b0;
    repeat (T) @(negedge clk_25);
    for (int i = 0; i < 4; i++) begin
      midi_rx = b[i];
      repeat (T) @(negedge clk_25);
    end
    midi_rx = b[4];
    repeat (H) @(negedge clk_25);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk_25);
      #1;
      check("rst_mid_outputs", int'(rx_valid == 0 && rx_data == 0 && fifo_count == 0 &&
            busy == 0 && frame_err == 0 && overrun == 0 && err_count == 0), 1);
    end
    @(negedge clk_25);
    rst = 1'b0;
    idle(2 * T);
    exp_q.push_back(8'h7F);
    ready_mode = 1;
    send_frame(8'h7F, 1'b1, 1'b0, c);
    idle(10);
    ready_mode = 0;
    check("rst_only_7f", exp_q.size(), 0);
    check("rst_count_end", fifo_count, 0);

    // randomized traffic with a random consumer
    ready_mode = 2;
    f0 = n_ferr;
    o0 = n_ovr;
    nerr_exp = 0;
    repeat (30) begin
      int r;
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r < 7) begin
        exp_q.push_back(b);
        send_frame(b, 1'b1, 1'b0, c);
        idle($urandom_range(0, T));
      end else if (r < 9) begin
        midi_rx = 1'b0;
        repeat ($urandom_range(1, H - 2)) @(negedge clk_25);
        idle(T + $urandom_range(0, T));
      end else begin
        nerr_exp++;
        send_frame(b, 1'b0, 1'b0, c);
        repeat ($urandom_range(1, T)) @(negedge clk_25);
        idle(T);
      end
    end
    ready_mode = 1;
    idle(20);
    ready_mode = 0;
    check("rand_drained", exp_q.size(), 0);
    check("rand_ferr", n_ferr - f0, nerr_exp);
    check("rand_overrun", n_ovr - o0, 0);
    check("rand_err_count", err_count, ERRCNT_ON ? nerr_exp : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
